// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared gameplay constants: play mode, button indices, default timing.
package tetris_pkg;

    localparam logic [1:0] MODE_PLAY = 2'b01;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_ROTATE = 3;

    localparam int CLK_HZ     = 50_000_000;
    localparam int DROP_DIV   = CLK_HZ;
    localparam int REPEAT_DIV = CLK_HZ / 5;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser and debouncer; debouncer built only with GAMEPLAY_INPUT_DEBOUNCE_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic level_next
);
    import tetris_pkg::*;

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

`ifdef GAMEPLAY_INPUT_DEBOUNCE_EN
    localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // level_next is exported so the repeat counter can see a change in the same edge it lands.
    always_comb begin
        cnt_next   = '0;
        level_next = level;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_next = ~level;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            level <= level_next;
        end
    end
`else
    assign level_next = sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else begin
            level <= sync2;
        end
    end
`endif

endmodule

// File: rtl/gameplay_input_timer.sv
// rtl/gameplay_input_timer.sv - button front end plus level-scaled drop tick and auto-repeat tick.
// Debouncing is enabled by defining GAMEPLAY_INPUT_DEBOUNCE_EN.
module gameplay_input_timer #(
    parameter int DROP_DIV        = 50_000_000,
    parameter int DROP_STEP       = 3_000_000,
    parameter int DROP_MIN        = 5_000_000,
    parameter int REPEAT_DIV      = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic [3:0] KEY_n,
    input  logic [1:0] mode,
    input  logic [3:0] level,
    output logic       left,
    output logic       down,
    output logic       right,
    output logic       rotate,
    output logic       SecEn,
    output logic       adjustSecEn
);
    import tetris_pkg::*;

    localparam int DROP_W = clog2_min1((DROP_DIV > DROP_MIN) ? DROP_DIV : DROP_MIN);
    localparam int REP_W  = clog2_min1(REPEAT_DIV);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DIV - 1);

    logic [3:0] held;
    logic [3:0] held_next;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk       (Clk),
            .rst_n     (Resetn),
            .key_n     (KEY_n[i]),
            .level     (held[i]),
            .level_next(held_next[i])
        );
    end

    assign left   = held[BTN_LEFT];
    assign down   = held[BTN_DOWN];
    assign right  = held[BTN_RIGHT];
    assign rotate = held[BTN_ROTATE];

    logic [31:0] drop_dec;
    logic [31:0] period;

    // Saturate at DROP_MIN rather than letting the subtraction wrap at high levels.
    always_comb begin
        drop_dec = 32'(level) * 32'(DROP_STEP);
        period   = 32'(DROP_MIN);
        if (drop_dec < 32'(DROP_DIV) && (32'(DROP_DIV) - drop_dec) > 32'(DROP_MIN)) begin
            period = 32'(DROP_DIV) - drop_dec;
        end
    end

    logic [DROP_W-1:0] drop_cnt;
    logic              drop_hit;

    assign drop_hit = (32'(drop_cnt) >= (period - 32'd1));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            drop_cnt <= '0;
            SecEn    <= 1'b0;
        end else if (mode != MODE_PLAY) begin
            drop_cnt <= '0;
            SecEn    <= 1'b0;
        end else begin
            SecEn    <= drop_hit;
            drop_cnt <= drop_hit ? '0 : drop_cnt + 1'b1;
        end
    end

    logic [REP_W-1:0] rep_cnt;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            rep_cnt     <= '0;
            adjustSecEn <= 1'b0;
        end else begin
            adjustSecEn <= 1'b0;
            if (held_next == 4'd0 || held_next != held) begin
                rep_cnt <= '0;
            end else if (rep_cnt == REP_LAST) begin
                rep_cnt     <= '0;
                adjustSecEn <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gameplay_input_timer.sv
// tb/tb_gameplay_input_timer.sv - directed bench for gameplay_input_timer, both debounce builds.
module tb_gameplay_input_timer;

    localparam int DROP_DIV   = 20;
    localparam int DROP_STEP  = 4;
    localparam int DROP_MIN   = 4;
    localparam int REPEAT_DIV = 5;
    localparam int DEB_CYC    = 3;
`ifdef GAMEPLAY_INPUT_DEBOUNCE_EN
    localparam int LAT = 2 + DEB_CYC;
`else
    localparam int LAT = 3;
`endif

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic [3:0] KEY_n = 4'hF;
    logic [1:0] mode = 2'b00;
    logic [3:0] level = 4'd0;
    logic       left, down, right, rotate, SecEn, adjustSecEn;

    int checks = 0;
    int fails  = 0;

    gameplay_input_timer #(
        .DROP_DIV       (DROP_DIV),
        .DROP_STEP      (DROP_STEP),
        .DROP_MIN       (DROP_MIN),
        .REPEAT_DIV     (REPEAT_DIV),
        .DEBOUNCE_CYCLES(DEB_CYC)
    ) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .KEY_n      (KEY_n),
        .mode       (mode),
        .level      (level),
        .left       (left),
        .down       (down),
        .right      (right),
        .rotate     (rotate),
        .SecEn      (SecEn),
        .adjustSecEn(adjustSecEn)
    );

    always #5 Clk = ~Clk;

    function automatic logic [5:0] outs();
        return {left, down, right, rotate, SecEn, adjustSecEn};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_sec(input int max, output int n);
        int i = 0;
        n = -1;
        while (n < 0 && i < max) begin
            tick();
            i++;
            if (SecEn === 1'b1) n = i;
        end
    endtask

    task automatic wait_adj(input int max, output int n);
        int i = 0;
        n = -1;
        while (n < 0 && i < max) begin
            tick();
            i++;
            if (adjustSecEn === 1'b1) n = i;
        end
    endtask

    task automatic settle();
        KEY_n = 4'hF;
        mode  = 2'b00;
        repeat (2 * LAT + 10) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (outs() !== 6'd0) begin
            fails++;
            $display("FAIL reset_state: got %b want 000000", outs());
        end
        Resetn = 1'b1;
        mode   = 2'b01;
        KEY_n  = 4'b1110;
        repeat (12) tick();
        checks++;
        if (left !== 1'b1) begin
            fails++;
            $display("FAIL reset_precondition_left: got %b want 1", left);
        end
        Resetn = 1'b0;
        #1;
        checks++;
        if (outs() !== 6'd0) begin
            fails++;
            $display("FAIL reset_async_clear: got %b want 000000", outs());
        end
        repeat (2) tick();
        Resetn = 1'b1;
        repeat (LAT - 1) tick();
        checks++;
        if (left !== 1'b0) begin
            fails++;
            $display("FAIL reset_left_early: got %b want 0", left);
        end
        tick();
        checks++;
        if (left !== 1'b1) begin
            fails++;
            $display("FAIL reset_left_rise: got %b want 1", left);
        end
        settle();
    endtask

    task automatic test_bounce();
        logic seen = 1'b0;
        for (int ph = 0; ph < 10; ph++) begin
            KEY_n[0] = ph[0];
            repeat (2) begin
                tick();
                seen |= left;
            end
        end
`ifdef GAMEPLAY_INPUT_DEBOUNCE_EN
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bounce_reject: left seen %b want 0", seen);
        end
`endif
        KEY_n[0] = 1'b0;
        repeat (LAT - 1) tick();
        checks++;
        if (left !== 1'b0) begin
            fails++;
            $display("FAIL bounce_left_early: got %b want 0", left);
        end
        tick();
        checks++;
        if (left !== 1'b1) begin
            fails++;
            $display("FAIL bounce_left_rise: got %b want 1", left);
        end
        settle();
    endtask

    task automatic test_drop_level();
        int n;
        int lv[4]  = '{0, 2, 5, 15};
        int exp[4] = '{20, 12, 4, 4};
        level = 4'd0;
        mode  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            level = 4'(lv[k]);
            for (int r = 0; r < 2; r++) begin
                wait_sec(40, n);
                checks++;
                if (n !== exp[k]) begin
                    fails++;
                    $display("FAIL drop_level%0d_interval%0d: got %0d want %0d", lv[k], r, n, exp[k]);
                end
            end
        end
        mode  = 2'b00;
        level = 4'd0;
        tick();
    endtask

    task automatic test_level_change();
        int n;
        logic seen = 1'b0;
        mode  = 2'b00;
        level = 4'd0;
        tick();
        mode = 2'b01;
        repeat (15) begin
            tick();
            seen |= SecEn;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL level_change_precount: SecEn seen %b want 0", seen);
        end
        level = 4'd3;
        wait_sec(10, n);
        checks++;
        if (n !== 1) begin
            fails++;
            $display("FAIL level_change_immediate: got %0d want 1", n);
        end
        for (int r = 0; r < 2; r++) begin
            wait_sec(20, n);
            checks++;
            if (n !== 8) begin
                fails++;
                $display("FAIL level_change_interval%0d: got %0d want 8", r, n);
            end
        end
        mode  = 2'b00;
        level = 4'd0;
        tick();
    endtask

    task automatic test_mode_gating();
        int n;
        logic seen = 1'b0;
        mode = 2'b00;
        repeat (50) begin
            tick();
            seen |= SecEn;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL mode_gate_idle: SecEn seen %b want 0", seen);
        end
        mode = 2'b01;
        wait_sec(40, n);
        checks++;
        if (n !== 20) begin
            fails++;
            $display("FAIL mode_gate_first: got %0d want 20", n);
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_repeat();
        int n;
        int i;
        logic seen = 1'b0;
        KEY_n[2] = 1'b0;
        n = -1;
        i = 0;
        while (n < 0 && i < 20) begin
            tick();
            i++;
            if (right === 1'b1) n = i;
        end
        checks++;
        if (n !== LAT) begin
            fails++;
            $display("FAIL repeat_right_latency: got %0d want %0d", n, LAT);
        end
        for (int r = 0; r < 3; r++) begin
            wait_adj(20, n);
            checks++;
            if (n !== 5) begin
                fails++;
                $display("FAIL repeat_interval%0d: got %0d want 5", r, n);
            end
        end
        repeat (8 - LAT) tick();
        KEY_n[3] = 1'b0;
        n = -1;
        i = 0;
        while (n < 0 && i < 20) begin
            tick();
            i++;
            if (rotate === 1'b1) n = i;
        end
        checks++;
        if (n !== LAT) begin
            fails++;
            $display("FAIL repeat_rotate_latency: got %0d want %0d", n, LAT);
        end
        wait_adj(20, n);
        checks++;
        if (n !== 5) begin
            fails++;
            $display("FAIL repeat_restart: got %0d want 5", n);
        end
        KEY_n = 4'hF;
        repeat (LAT) tick();
        checks++;
        if (outs() !== 6'd0) begin
            fails++;
            $display("FAIL repeat_release_outputs: got %b want 000000", outs());
        end
        repeat (20) begin
            tick();
            seen |= adjustSecEn;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL repeat_release_quiet: adjustSecEn seen %b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_drop_level();
        test_level_change();
        test_mode_gating();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
